// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer and its SIPO counterpart.
package piso_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // Word width shared with the 4-bit SIPO receiver.
  localparam int unsigned DefaultWidth = 4;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit position counter for the serializer: clears on a word load, counts shifted bits.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic at_last
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastVal = CntW'(WIDTH - 1);

  logic [CntW-1:0] count_q, count_d;

  assign at_last = (count_q == LastVal);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && !at_last) begin
      // Saturate at the last position so the count never wraps.
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out serializer with a valid/ready load port and a last-bit flag.
module piso_shift_register
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, sreg_shifted;
  logic             shifting;
  logic             at_last;
  logic             accept;

  assign shifting     = (state_q == StShift);
  // Ready in the last-bit cycle lets the next word follow without a gap.
  assign load_ready   = !shifting || at_last;
  assign accept       = load_valid && load_ready;
  assign sreg_shifted = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);

  piso_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .inc    (shifting),
    .at_last(at_last)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          state_d = StShift;
          sreg_d  = din;
        end
      end
      StShift: begin
        if (at_last && load_valid) begin
          sreg_d = din;
        end else begin
          sreg_d = sreg_shifted;
          if (at_last) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

  assign sout       = shifting && (LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1]);
  assign sout_valid = shifting;
  assign sout_last  = shifting && at_last;
  assign busy       = shifting;

endmodule

// File: tb/tb_piso_shift_register.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_piso_shift_register;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lv4 = 1'b0;
  logic [3:0] din4 = '0;
  logic       lv8 = 1'b0;
  logic [7:0] din8 = '0;
  logic       rdy4, sout4, val4, last4, busy4;
  logic       rdy8, sout8, val8, last8, busy8;
  logic [3:0] sipo_q;

  int n_cmp = 0;
  int n_bad = 0;

  bit m4[$];
  bit m8[$];

  always #5 clk = ~clk;

  piso_shift_register u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .load_valid(lv4),
    .load_ready(rdy4),
    .din       (din4),
    .sout      (sout4),
    .sout_valid(val4),
    .sout_last (last4),
    .busy      (busy4)
  );

  piso_shift_register #(
    .WIDTH    (8),
    .LSB_FIRST(1'b0)
  ) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .load_valid(lv8),
    .load_ready(rdy8),
    .din       (din8),
    .sout      (sout8),
    .sout_valid(val8),
    .sout_last (last8),
    .busy      (busy8)
  );

  // 4-bit SIPO receiver fed by the default-width serializer.
  always @(posedge clk) begin
    if (rst) sipo_q <= '0;
    else     sipo_q <= {sout4, sipo_q[3:1]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of bits still to appear on sout, front = current bit.
  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      m4.delete();
      m8.delete();
    end else begin
      acc = lv4 && (m4.size() <= 1);
      if (m4.size() > 0) void'(m4.pop_front());
      if (acc) for (int i = 0; i < 4; i++) m4.push_back(din4[i]);
      acc = lv8 && (m8.size() <= 1);
      if (m8.size() > 0) void'(m8.pop_front());
      if (acc) for (int i = 7; i >= 0; i--) m8.push_back(din8[i]);
    end
  end

  always @(negedge clk) begin
    int s4, s8;
    s4 = m4.size();
    s8 = m8.size();
    chk("m4.sout",  {31'd0, sout4}, (s4 > 0) ? {31'd0, m4[0]} : 32'd0);
    chk("m4.valid", {31'd0, val4},  {31'd0, s4 > 0});
    chk("m4.last",  {31'd0, last4}, {31'd0, s4 == 1});
    chk("m4.busy",  {31'd0, busy4}, {31'd0, s4 > 0});
    chk("m4.ready", {31'd0, rdy4},  {31'd0, s4 <= 1});
    chk("m8.sout",  {31'd0, sout8}, (s8 > 0) ? {31'd0, m8[0]} : 32'd0);
    chk("m8.valid", {31'd0, val8},  {31'd0, s8 > 0});
    chk("m8.last",  {31'd0, last8}, {31'd0, s8 == 1});
    chk("m8.busy",  {31'd0, busy8}, {31'd0, s8 > 0});
    chk("m8.ready", {31'd0, rdy8},  {31'd0, s8 <= 1});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int e2[4] = '{1, 1, 0, 1};
    int e3[8] = '{0, 1, 0, 1, 1, 0, 1, 0};
    int e5[4] = '{1, 1, 0, 0};
    int e6[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    // Reset held two edges with a load pending: nothing is captured.
    lv4 = 1'b1;
    din4 = 4'hF;
    repeat (2) @(posedge clk);
    tick();
    rst = 1'b0;
    lv4 = 1'b0;
    chk("rst.sout", {31'd0, sout4}, 0);
    chk("rst.valid", {31'd0, val4}, 0);
    chk("rst.last", {31'd0, last4}, 0);
    chk("rst.busy", {31'd0, busy4}, 0);
    chk("rst.ready", {31'd0, rdy4}, 1);
    tick();
    chk("rst.nocap", {31'd0, busy4}, 0);

    // Single word 1011, LSB first.
    lv4 = 1'b1;
    din4 = 4'b1011;
    tick();
    lv4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("single.sout", {31'd0, sout4}, e2[i]);
      chk("single.valid", {31'd0, val4}, 1);
      chk("single.last", {31'd0, last4}, (i == 3) ? 1 : 0);
      tick();
    end
    chk("single.idle", {31'd0, val4}, 0);

    // Back-to-back A then 5.
    lv4 = 1'b1;
    din4 = 4'hA;
    tick();
    din4 = 4'h5;
    for (int i = 0; i < 8; i++) begin
      chk("b2b.sout", {31'd0, sout4}, e3[i]);
      chk("b2b.valid", {31'd0, val4}, 1);
      chk("b2b.last", {31'd0, last4}, (i == 3 || i == 7) ? 1 : 0);
      chk("b2b.ready", {31'd0, rdy4}, (i == 3 || i == 7) ? 1 : 0);
      if (i == 4) lv4 = 1'b0;
      tick();
    end
    chk("b2b.idle", {31'd0, val4}, 0);

    // Loopback into SIPO.
    lv4 = 1'b1;
    din4 = 4'b0110;
    tick();
    lv4 = 1'b0;
    repeat (4) tick();
    chk("loop.sipo", {28'd0, sipo_q}, 32'h6);

    // Reset mid-word, then a fresh word.
    lv4 = 1'b1;
    din4 = 4'hF;
    tick();
    lv4 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.sout", {31'd0, sout4}, 0);
    chk("abort.valid", {31'd0, val4}, 0);
    chk("abort.busy", {31'd0, busy4}, 0);
    chk("abort.ready", {31'd0, rdy4}, 1);
    lv4 = 1'b1;
    din4 = 4'h3;
    tick();
    lv4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fresh.sout", {31'd0, sout4}, e5[i]);
      tick();
    end
    chk("fresh.idle", {31'd0, val4}, 0);

    // WIDTH=8 MSB first, stray load pulses on bits 1-7 ignored.
    lv8 = 1'b1;
    din8 = 8'hA5;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("w8.sout", {31'd0, sout8}, e6[i]);
      chk("w8.last", {31'd0, last8}, (i == 7) ? 1 : 0);
      lv8 = (i < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
      din8 = 8'($urandom);
      tick();
    end
    chk("w8.idle", {31'd0, val8}, 0);

    // Randomized traffic on both instances, checked by the model.
    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom_range(0, 79) == 0);
      lv4  = ($urandom_range(0, 3) != 0);
      din4 = 4'($urandom);
      lv8  = ($urandom_range(0, 2) != 0);
      din8 = 8'($urandom);
      tick();
    end
    rst = 1'b0;
    lv4 = 1'b0;
    lv8 = 1'b0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_shift_register.md
Name: piso_shift_register

Overview:
Parallel-in serial-out serializer, the transmit-side counterpart of the team's 4-bit SIPO shift register. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock. It flags the last bit of each word and supports gap-free back-to-back words. With default parameters, its sout drives the SIPO serial input directly, so a loaded word reappears on the SIPO parallel output.

Parameters:
WIDTH, 4, word width in bits (>=2)
LSB_FIRST, 1, 1 = transmit din[0] first (matches SIPO bit placement); 0 = transmit din[WIDTH-1] first

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
load_valid  input  1  din holds a word to transmit
load_ready  output  1  block can accept a word this cycle
din  input  WIDTH  parallel word, sampled when load_valid && load_ready
sout  output  1  serial data bit, registered
sout_valid  output  1  sout carries a valid bit this cycle
sout_last  output  1  sout is the final bit of the current word
busy  output  1  a word is in flight (state SHIFT)

Behaviour:
- Reset (rst=1 at rising edge): state=IDLE, shift register=0, bit counter=0. Registered outputs: sout=0, sout_valid=0, sout_last=0, busy=0. load_ready is combinational and reads 1 in IDLE after reset. rst has priority over every other input, including an accepted load in the same cycle.
- States: IDLE, SHIFT.
- IDLE: load_ready=1, sout=0, sout_valid=0. When load_valid=1 at an edge, capture din, set counter=0 and go to SHIFT. The first bit appears on sout in the cycle after the accept edge (latency 1).
- SHIFT: sout_valid=1 and busy=1.
  - sout = sreg[0] when LSB_FIRST=1, otherwise sreg[WIDTH-1].
  - Each edge shifts sreg by one position toward the output end, fills with 0, and increments the counter.
  - sout_last=1 exactly when counter==WIDTH-1.
- load_ready in SHIFT: asserted only in the last-bit cycle (counter==WIDTH-1). load_valid in any other SHIFT cycle is ignored, and din is not sampled.
- Last-bit edge:
  - If load_valid=1, load the new word, reset counter=0 and stay in SHIFT. The first bit of the next word follows with no idle cycle.
  - Otherwise return to IDLE. sout and sout_valid go to 0 in the next cycle.
- Counter width is clog2(WIDTH). It never wraps past WIDTH-1.
- Exactly WIDTH sout_valid cycles per accepted word. Exactly one sout_last pulse per word.
- Reset mid-word: abort the transmission immediately. Outputs take their reset values on the next cycle, and the partial word is discarded (not resumed).
- din may change freely when not being sampled.

Decomposition:
- Shared package piso_pkg holds:
  - state enum {IDLE, SHIFT}
  - counter-width constant function (clog2)
  - default WIDTH constant shared with the SIPO block
- Natural sub-module: piso_bit_counter. It is a synchronous, reset-to-zero counter with inputs clear and inc, and an output at_last (count==WIDTH-1).
- Shift register and FSM stay in the top module.

Test Plan:
1. Reset check: hold rst 2 cycles with load_valid=1 and din=4'hF -> sout=0, sout_valid=0, sout_last=0, busy=0, load_ready=1 after release, and no word is captured.
2. Single word: load din=4'b1011 once (LSB_FIRST=1) -> sout=1,1,0,1 on cycles 1-4 after accept. sout_valid=1 for those 4 cycles. sout_last=1 only on cycle 4. Then IDLE with sout_valid=0.
3. Back-to-back: hold load_valid=1 with 4'hA then 4'h5 -> 8 consecutive valid bits 0,1,0,1,1,0,1,0 with no gap. sout_last on bits 4 and 8. load_ready=1 only on cycle 4 of each word.
4. Loopback: connect sout to the SIPO serial input, load 4'b0110 -> after the 4th valid bit's edge, SIPO q=4'b0110.
5. Reset mid-word: load 4'hF and assert rst on bit 2 -> next cycle all outputs 0, state IDLE. A fresh load of 4'h3 transmits 1,1,0,0 correctly.
6. Parameter variant WIDTH=8, LSB_FIRST=0: load 8'hA5 -> sout=1,0,1,0,0,1,0,1 with sout_last on bit 8. load_valid pulses on bits 1-7 are ignored.
